// File: rtl/mic_pkg.sv
// Shared definitions for the mic controller: FSM encoding and instruction field positions.
// No logic here; imported by every mic_* module.
package mic_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_MRD   = 2'd1,
        ST_EXEC  = 2'd2,
        ST_MWR   = 2'd3
    } state_t;

    // Instruction word fields
    localparam int BIT_CI = 15;   // 1 = C-instruction, 0 = A-instruction
    localparam int BIT_A  = 12;   // a: ALU y operand from M latch instead of A
    localparam int C_HI   = 11;   // c: zx nx zy ny f no
    localparam int C_LO   = 6;
    localparam int D_A    = 5;    // d: destination A
    localparam int D_D    = 4;    // d: destination D
    localparam int D_M    = 3;    // d: destination memory
    localparam int J_HI   = 2;
    localparam int J_LO   = 0;

    // Jump condition bits within j[2:0]
    localparam int J_LT   = 2;
    localparam int J_EQ   = 1;
    localparam int J_GT   = 0;

    localparam int IR_W   = 13;   // bits 15:13 of a C-instruction are not retained

endpackage

// File: rtl/mic_jmp.sv
// Jump condition evaluator: combinational, zero latency, no flow control.
// Takes the branch when any requested relation (lt, eq, gt) holds for the ALU result.
module mic_jmp
    import mic_pkg::*;
(
    input  logic [2:0] j,
    input  logic       nv,
    input  logic       zr,
    output logic       take
);

    assign take = (j[J_LT] & nv)
                | (j[J_EQ] & zr)
                | (j[J_GT] & ~nv & ~zr);

endmodule

// File: rtl/mic_ctrl.sv
// Hack-style CPU controller: A-inst 1 cycle; C-inst FETCH->[MRD]->EXEC->[MWR] (EXEC exactly 1 cycle).
// Stalls in FETCH on inst_vld, in MRD on m_rvld and in MWR on m_wack; the ALU lives outside.
module mic_ctrl
    import mic_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] inst,
    input  logic        inst_vld,
    output logic        inst_rdy,
    output logic [14:0] pc,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic        zx,
    output logic        nx,
    output logic        zy,
    output logic        ny,
    output logic        f,
    output logic        no,
    input  logic [15:0] alu_out,
    input  logic        alu_nv,
    input  logic        alu_zr,
    output logic [14:0] m_addr,
    output logic        m_rd,
    input  logic [15:0] m_rdata,
    input  logic        m_rvld,
    output logic        m_wr,
    output logic [15:0] m_wdata,
    input  logic        m_wack
);

    state_t            state, nxt;
    logic [15:0]       a_q, d_q, r_q, m_q;
    logic [IR_W-1:0]   ir_q;
    logic [14:0]       pc_q;
    logic [14:0]       wa_q;
    logic              take;

    mic_jmp u_jmp (
        .j    (ir_q[J_HI:J_LO]),
        .nv   (alu_nv),
        .zr   (alu_zr),
        .take (take)
    );

    always_comb begin
        nxt      = state;
        inst_rdy = 1'b0;
        m_rd     = 1'b0;
        m_wr     = 1'b0;
        case (state)
            ST_FETCH: begin
                inst_rdy = 1'b1;
                if (inst_vld && inst[BIT_CI])
                    nxt = inst[BIT_A] ? ST_MRD : ST_EXEC;
            end
            ST_MRD: begin
                m_rd = 1'b1;
                if (m_rvld)
                    nxt = ST_EXEC;
            end
            ST_EXEC: begin
                nxt = ir_q[D_M] ? ST_MWR : ST_FETCH;
            end
            ST_MWR: begin
                m_wr = 1'b1;
                if (m_wack)
                    nxt = ST_FETCH;
            end
            default: nxt = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FETCH;
            a_q   <= '0;
            d_q   <= '0;
            r_q   <= '0;
            m_q   <= '0;
            ir_q  <= '0;
            pc_q  <= '0;
            wa_q  <= '0;
        end else begin
            state <= nxt;
            case (state)
                ST_FETCH: begin
                    if (inst_vld) begin
                        if (!inst[BIT_CI]) begin
                            a_q  <= inst;
                            pc_q <= pc_q + 15'd1;
                        end else begin
                            ir_q <= inst[IR_W-1:0];
                        end
                    end
                end
                ST_MRD: begin
                    if (m_rvld)
                        m_q <= m_rdata;
                end
                ST_EXEC: begin
                    r_q  <= alu_out;
                    // Write address must be the A seen before this instruction writes A.
                    wa_q <= a_q[14:0];
                    if (ir_q[D_A])
                        a_q <= alu_out;
                    if (ir_q[D_D])
                        d_q <= alu_out;
                    pc_q <= take ? a_q[14:0] : pc_q + 15'd1;
                end
                default: ;
            endcase
        end
    end

    assign pc      = pc_q;
    assign alu_x   = d_q;
    assign alu_y   = ir_q[BIT_A] ? m_q : a_q;
    assign zx      = ir_q[C_HI];
    assign nx      = ir_q[C_HI-1];
    assign zy      = ir_q[C_HI-2];
    assign ny      = ir_q[C_HI-3];
    assign f       = ir_q[C_HI-4];
    assign no      = ir_q[C_LO];
    assign m_addr  = (state == ST_MWR) ? wa_q : a_q[14:0];
    assign m_wdata = r_q;

endmodule

// File: tb/tb_mic_ctrl.sv
// Directed bench for mic_ctrl with a behavioural Hack ALU and hand-computed expectations.
module tb_mic_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] inst;
    logic        inst_vld;
    logic        inst_rdy;
    logic [14:0] pc;
    logic [15:0] alu_x, alu_y;
    logic        zx, nx, zy, ny, f, no;
    logic [15:0] alu_out;
    logic        alu_nv, alu_zr;
    logic [14:0] m_addr;
    logic        m_rd;
    logic [15:0] m_rdata;
    logic        m_rvld;
    logic        m_wr;
    logic [15:0] m_wdata;
    logic        m_wack;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mic_ctrl dut (
        .clk(clk), .rst(rst),
        .inst(inst), .inst_vld(inst_vld), .inst_rdy(inst_rdy), .pc(pc),
        .alu_x(alu_x), .alu_y(alu_y),
        .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
        .alu_out(alu_out), .alu_nv(alu_nv), .alu_zr(alu_zr),
        .m_addr(m_addr), .m_rd(m_rd), .m_rdata(m_rdata), .m_rvld(m_rvld),
        .m_wr(m_wr), .m_wdata(m_wdata), .m_wack(m_wack)
    );

    // Hack ALU
    logic [15:0] ax, ay, ares;
    always_comb begin
        ax = zx ? 16'h0000 : alu_x;
        ax = nx ? ~ax : ax;
        ay = zy ? 16'h0000 : alu_y;
        ay = ny ? ~ay : ay;
        ares = f ? (ax + ay) : (ax & ay);
        alu_out = no ? ~ares : ares;
        alu_nv  = alu_out[15];
        alu_zr  = (alu_out == 16'h0000);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        int guard = 0;
        while (!inst_rdy && guard < 20) begin
            tick();
            guard++;
        end
        check("send_rdy", {31'd0, inst_rdy}, 32'd1);
        inst     = w;
        inst_vld = 1'b1;
        tick();
        inst_vld = 1'b0;
        inst     = 16'h0000;
    endtask

    initial begin
        int cnt;
        rst = 1'b1; inst = '0; inst_vld = 1'b0;
        m_rdata = '0; m_rvld = 1'b0; m_wack = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_rdy",   {31'd0, inst_rdy}, 32'd1);
        check("rst_mrd",   {31'd0, m_rd},     32'd0);
        check("rst_mwr",   {31'd0, m_wr},     32'd0);
        check("rst_pc",    {17'd0, pc},       32'd0);
        check("rst_x",     {16'd0, alu_x},    32'd0);
        check("rst_y",     {16'd0, alu_y},    32'd0);
        check("rst_wdata", {16'd0, m_wdata},  32'd0);

        // A-instruction
        send(16'h0005);
        check("ainst_a",   {17'd0, m_addr},   32'h5);
        check("ainst_y",   {16'd0, alu_y},    32'h5);
        check("ainst_pc",  {17'd0, pc},       32'd1);
        check("ainst_rdy", {31'd0, inst_rdy}, 32'd1);

        // Idle with no valid instruction
        tick(); tick(); tick();
        check("idle_pc",  {17'd0, pc},       32'd1);
        check("idle_rdy", {31'd0, inst_rdy}, 32'd1);

        // D=A
        send(16'hEC10);
        check("da_rdy",  {31'd0, inst_rdy},               32'd0);
        check("da_y",    {16'd0, alu_y},                  32'h5);
        check("da_c",    {26'd0, zx, nx, zy, ny, f, no},  32'b110000);
        check("da_mrd",  {31'd0, m_rd},                   32'd0);
        tick();
        check("da_d",    {16'd0, alu_x},    32'h5);
        check("da_pc",   {17'd0, pc},       32'd2);
        check("da_mwr",  {31'd0, m_wr},     32'd0);
        check("da_fetch",{31'd0, inst_rdy}, 32'd1);

        // M=D+1 with write ack after 3 wait cycles
        send(16'h0010);
        send(16'hE7C8);
        tick();
        check("mw_addr",  {17'd0, m_addr},  32'h10);
        check("mw_wdata", {16'd0, m_wdata}, 32'h6);
        check("mw_pc",    {17'd0, pc},      32'd4);
        cnt = 0;
        while (m_wr && cnt < 20) begin
            cnt++;
            m_wack = (cnt == 4);
            tick();
        end
        m_wack = 1'b0;
        check("mw_hold",  cnt,                  32'd4);
        check("mw_done",  {31'd0, m_wr},        32'd0);
        check("mw_fetch", {31'd0, inst_rdy},    32'd1);
        check("mw_d",     {16'd0, alu_x},       32'h5);

        // D=M with read data after 2 wait cycles
        send(16'hFC10);
        check("mr_rd",   {31'd0, m_rd},   32'd1);
        check("mr_addr", {17'd0, m_addr}, 32'h10);
        m_rdata = 16'h1234;
        cnt = 0;
        while (m_rd && cnt < 20) begin
            cnt++;
            m_rvld = (cnt == 3);
            tick();
        end
        m_rvld = 1'b0;
        check("mr_hold", cnt,             32'd3);
        check("mr_y",    {16'd0, alu_y},  32'h1234);
        tick();
        check("mr_d",    {16'd0, alu_x},  32'h1234);
        check("mr_pc",   {17'd0, pc},     32'd5);
        // Stray read-valid in FETCH must not touch the M latch
        m_rdata = 16'hBEEF; m_rvld = 1'b1;
        tick();
        m_rvld = 1'b0;
        check("mr_stray", {16'd0, alu_y}, 32'h1234);

        // Jumps: A=0x0100, D=-1
        send(16'h0100);
        send(16'hEE90);
        tick();
        check("j_dm1", {16'd0, alu_x}, 32'hFFFF);
        check("j_pc7", {17'd0, pc},    32'd7);
        send(16'hE304);
        tick();
        check("jlt_pc", {17'd0, pc}, 32'h100);
        send(16'hE301);
        tick();
        check("jgt_pc", {17'd0, pc}, 32'h101);
        // A=D;JLT jumps to the old A
        send(16'hE324);
        tick();
        check("jlta_pc", {17'd0, pc},     32'h100);
        check("jlta_a",  {17'd0, m_addr}, 32'h7FFF);

        // AM=D+1: write goes to the pre-EXEC A
        send(16'h0020);
        send(16'hE7E8);
        tick();
        check("am_addr",  {17'd0, m_addr},  32'h20);
        check("am_wdata", {16'd0, m_wdata}, 32'h0);
        m_wack = 1'b1;
        tick();
        m_wack = 1'b0;
        check("am_newa",  {17'd0, m_addr},  32'h0);
        check("am_pc",    {17'd0, pc},      32'h102);

        // pc wrap via 0;JMP to 0x7FFF
        send(16'h7FFF);
        send(16'hEA87);
        tick();
        check("jmp_pc",  {17'd0, pc}, 32'h7FFF);
        send(16'h0003);
        check("wrap_pc", {17'd0, pc}, 32'h0);

        // Reset during MWR
        send(16'hE308);
        tick();
        check("rmw_wr", {31'd0, m_wr}, 32'd1);
        check("rmw_pc", {17'd0, pc},   32'd1);
        rst = 1'b1;
        tick();
        check("rmw_wr0",  {31'd0, m_wr},     32'd0);
        check("rmw_pc0",  {17'd0, pc},       32'd0);
        check("rmw_d0",   {16'd0, alu_x},    32'd0);
        check("rmw_a0",   {16'd0, alu_y},    32'd0);
        check("rmw_addr", {17'd0, m_addr},   32'd0);
        check("rmw_rdy",  {31'd0, inst_rdy}, 32'd1);
        rst = 1'b0;
        tick();
        check("post_rdy", {31'd0, inst_rdy}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mic_ctrl.md
MIC_CTRL -- requirements
Module: mic_ctrl

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: inst  in  16  instruction word; inst_vld  in  1  inst valid; inst_rdy  out  1  instruction accepted when inst_vld&inst_rdy; pc  out  15  program counter.
REQ-004 SHALL have ALU-facing ports: alu_x  out  16  D register; alu_y  out  16  A register, or M latch when inst bit12=1; zx,nx,zy,ny,f,no  out  1 each  latched inst bits 11..6.
REQ-005 SHALL have ports: alu_out  in  16  ALU result; alu_nv  in  1  result negative; alu_zr  in  1  result zero.
REQ-006 SHALL have memory ports: m_addr  out  15  A[14:0]; m_rd  out  1; m_rdata  in  16; m_rvld  in  1; m_wr  out  1; m_wdata  out  16; m_wack  in  1.

Function
REQ-007 SHALL implement Moore FSM states FETCH, MRD, EXEC, MWR; inst_rdy=1 only in FETCH, m_rd=1 only in MRD, m_wr=1 only in MWR.
REQ-008 SHALL, in FETCH on handshake with inst[15]=0 (A-inst): load A<=inst, pc<=pc+1, remain in FETCH (1 cycle/instruction).
REQ-009 SHALL, in FETCH on handshake with inst[15]=1 (C-inst, bits 14:13 ignored): latch inst into IR; next state MRD if IR[12]=1, else EXEC.
REQ-010 SHALL hold MRD until m_rvld=1, latching M<=m_rdata on that edge, then go to EXEC; m_rvld is ignored in any other state.
REQ-011 SHALL in EXEC (exactly 1 cycle) capture alu_out into result register R; load A<=alu_out if IR[5]; load D<=alu_out if IR[4]; update pc; next state MWR if IR[3], else FETCH.
REQ-012 SHALL take jump when (IR[2]&alu_nv)|(IR[1]&alu_zr)|(IR[0]&~alu_nv&~alu_zr); taken -> pc<=A[14:0] value before this instruction's EXEC write, else pc<=pc+1.
REQ-013 SHALL use pre-EXEC A for m_addr throughout MRD and MWR of the same instruction, even when IR[5]=1.
REQ-014 SHALL drive m_wdata=R and hold m_wr until m_wack=1, then return to FETCH.
REQ-015 SHALL wrap pc from 0x7FFF to 0x0000 on increment.
REQ-016 SHALL stay in FETCH with no state change while inst_vld=0.
REQ-017 SHALL drive zx..no from IR continuously, and alu_y from IR[12]-selected source continuously.

Reset
REQ-018 SHALL on rst=1 set A=D=R=M-latch=IR=0, pc=0, state FETCH; after the reset edge inst_rdy=1, m_rd=0, m_wr=0.
REQ-019 SHALL abort any in-progress MRD/MWR on reset, dropping m_rd/m_wr on the same edge, with no register update from alu_out.

Structure
REQ-020 SHALL place state encoding, instruction field bit positions (a, c, d, j) and jump bit indices in shared package mic_pkg.
REQ-021 SHALL evaluate jump in a combinational sub-module mic_jmp (inputs j[2:0], nv, zr; output take); the ALU itself stays outside mic_ctrl.

Verification
REQ-022 SHALL cover: reset, inst=0x0005 valid -> A=0x0005, pc=1, inst_rdy=1 the next cycle.
REQ-023 SHALL cover: A=5, inst=0xEC10 (D=A) -> alu_y=5, zx..no=110000, D=5 after EXEC, pc incremented, no m_rd/m_wr.
REQ-024 SHALL cover: A=0x0010, D=5, inst=0xE7C8 (M=D+1), m_wack delayed 3 cycles -> m_addr=0x0010, m_wdata=6, m_wr held 4 cycles, then FETCH.
REQ-025 SHALL cover: inst=0xFC10 (D=M), m_rvld after 2 wait cycles with m_rdata=0x1234 -> m_rd held 3 cycles, D=0x1234.
REQ-026 SHALL cover: A=0x0100, D=0xFFFF: inst 0xE304 (D;JLT) -> pc=0x0100; inst 0xE301 (D;JGT) -> pc=old pc+1.
REQ-027 SHALL cover: pc=0x7FFF A-inst -> pc=0; rst asserted mid-MWR -> m_wr=0, pc=0, A=D=0 on that edge.
